key_step_conditioner: RTL and testbench

//  Input conditioning stage in front of the sequence-detector FSM.

---
 rtl/key_step_conditioner.sv | 198 +++++++++++++++++++
 tb/tb_key_step_conditioner.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/key_step_conditioner.sv
// Input conditioning for the sequence-detector FSM: synchronizes and debounces the
// pushbutton and the w switch, emitting one clk-wide step enable per debounced press.

// Multi-flop synchronizer for one asynchronous pin.
module ksc_sync #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the chain is reset too, so a pre-reset pin level cannot leak into the filter afterwards.
      sync_q <= {STAGES{RESET_VAL}};
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// Level filter: commits a new level after STABLE_CYCLES consecutive differing samples.
module ksc_filter #(
  parameter int STABLE_CYCLES = 4,
  parameter int CNT_W         = 18
) (
  input  logic clk,
  input  logic rst,
  input  logic sample_i,
  output logic level_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

  logic             level_q, level_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    // NOTE: every output gets a default first, so no path can infer a latch.
    level_d = level_q;
    cnt_d   = '0;
    if (sample_i != level_q) begin
      if (cnt_q == CNT_MAX) begin
        level_d = sample_i;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      level_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      level_q <= level_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level_o = level_q;

endmodule

module key_step_conditioner #(
  parameter int STABLE_CYCLES = 250000,
  parameter int SYNC_STAGES   = 2,
  parameter int PB_ACTIVE_LOW = 1,
  parameter int CNT_W         = 18
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pb_raw,
  input  logic       w_raw,
  output logic       step,
  output logic       pb_level,
  output logic       w_level,
  output logic [7:0] press_cnt
);

  localparam logic             PB_RELEASED_RAW = (PB_ACTIVE_LOW != 0);
  localparam logic [CNT_W-1:0] CNT_MAX         = CNT_W'(STABLE_CYCLES - 1);

  typedef enum logic [1:0] {
    RELEASED     = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } pb_state_e;

  logic pb_sync, w_sync;
  logic pb_pressed, pb_differ, pb_commit;

  pb_state_e        state_q, state_d;
  logic [CNT_W-1:0] pb_cnt_q, pb_cnt_d;
  logic             step_q, step_d;
  logic [7:0]       press_cnt_q, press_cnt_d;

  ksc_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(PB_RELEASED_RAW)) u_pb_sync (
    .clk (clk),
    .rst (rst),
    .d_i (pb_raw),
    .q_o (pb_sync)
  );

  ksc_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_w_sync (
    .clk (clk),
    .rst (rst),
    .d_i (w_raw),
    .q_o (w_sync)
  );

  // w needs only the stable level; it commits on the same edge rule as pb.
  ksc_filter #(.STABLE_CYCLES(STABLE_CYCLES), .CNT_W(CNT_W)) u_w_filter (
    .clk      (clk),
    .rst      (rst),
    .sample_i (w_sync),
    .level_o  (w_level)
  );

  assign pb_pressed = pb_sync ^ PB_RELEASED_RAW;
  assign pb_differ  = pb_pressed ^ pb_level;
  assign pb_commit  = pb_differ && (pb_cnt_q == CNT_MAX);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= RELEASED;
      pb_cnt_q    <= '0;
      step_q      <= 1'b0;
      press_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      pb_cnt_q    <= pb_cnt_d;
      step_q      <= step_d;
      press_cnt_q <= press_cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    pb_cnt_d    = '0;
    step_d      = 1'b0;
    press_cnt_d = press_cnt_q;
    case (state_q)
      RELEASED: begin
        if (pb_differ) begin
          state_d  = PRESS_WAIT;
          pb_cnt_d = pb_cnt_q + CNT_W'(1);
        end
      end
      PRESS_WAIT: begin
        if (!pb_differ) begin
          state_d = RELEASED;
        end else if (pb_commit) begin
          // The only transition that produces a step, so a long hold yields one pulse.
          state_d     = PRESSED;
          step_d      = 1'b1;
          press_cnt_d = press_cnt_q + 8'd1;
        end else begin
          pb_cnt_d = pb_cnt_q + CNT_W'(1);
        end
      end
      PRESSED: begin
        if (pb_differ) begin
          state_d  = RELEASE_WAIT;
          pb_cnt_d = pb_cnt_q + CNT_W'(1);
        end
      end
      RELEASE_WAIT: begin
        if (!pb_differ) begin
          state_d = PRESSED;
        end else if (pb_commit) begin
          state_d = RELEASED;
        end else begin
          pb_cnt_d = pb_cnt_q + CNT_W'(1);
        end
      end
      default: state_d = RELEASED;
    endcase
  end

  always_comb begin
    pb_level = (state_q == PRESSED) || (state_q == RELEASE_WAIT);
  end

  assign step      = step_q;
  assign press_cnt = press_cnt_q;

endmodule

// File: tb/tb_key_step_conditioner.sv
// Self-checking bench for key_step_conditioner: scenario table, multi-cycle corner
// sequences and randomized bouncing inputs against a sample-history reference model.
module tb_key_step_conditioner;

  localparam int STABLE        = 4;
  localparam int SYNC          = 2;
  localparam int PB_ACTIVE_LOW = 1;
  localparam int CNT_W         = 18;
  localparam int MAXE          = 16384;

  logic       clk = 1'b0;
  logic       rst;
  logic       pb_raw;
  logic       w_raw;
  logic       step;
  logic       pb_level;
  logic       w_level;
  logic [7:0] press_cnt;

  int checks     = 0;
  int failures   = 0;
  int steps_seen = 0;

  key_step_conditioner #(
    .STABLE_CYCLES (STABLE),
    .SYNC_STAGES   (SYNC),
    .PB_ACTIVE_LOW (PB_ACTIVE_LOW),
    .CNT_W         (CNT_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .pb_raw    (pb_raw),
    .w_raw     (w_raw),
    .step      (step),
    .pb_level  (pb_level),
    .w_level   (w_level),
    .press_cnt (press_cnt)
  );

  always #5 clk = ~clk;

  // Reference model: per-edge history of the pin levels (pb in pressed polarity).
  // A channel commits when the last STABLE values seen through the synchronizer
  // all disagree with its level and none predates the last commit or reset.
  bit         hist [2][MAXE];
  int         n_edge = 8;
  bit         m_lvl [2];
  int         last_evt [2];
  bit         m_step;
  logic [7:0] m_cnt;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic bit commit_due(input int ch);
    bit s;
    s = hist[ch][n_edge-SYNC];
    if (s == m_lvl[ch]) return 1'b0;
    if (n_edge - (STABLE - 1) <= last_evt[ch]) return 1'b0;
    for (int k = 0; k < STABLE; k++)
      if (hist[ch][n_edge-SYNC-k] != s) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_edge(input bit r, input bit pb, input bit w);
    if (n_edge >= MAXE) begin
      $display("FAIL model_range: got %0d expected below %0d", n_edge, MAXE);
      $fatal(1, "edge history exhausted");
    end
    hist[0][n_edge] = (PB_ACTIVE_LOW != 0) ? ~pb : pb;
    hist[1][n_edge] = w;
    m_step = 1'b0;
    if (r) begin
      for (int ch = 0; ch < 2; ch++) begin
        for (int k = 0; k < SYNC; k++) hist[ch][n_edge-k] = 1'b0;
        m_lvl[ch]    = 1'b0;
        last_evt[ch] = n_edge;
      end
      m_cnt = 8'd0;
    end else begin
      if (commit_due(1)) begin
        m_lvl[1]    = ~m_lvl[1];
        last_evt[1] = n_edge;
      end
      if (commit_due(0)) begin
        m_lvl[0]    = ~m_lvl[0];
        last_evt[0] = n_edge;
        if (m_lvl[0]) begin
          m_step = 1'b1;
          m_cnt  = m_cnt + 8'd1;
        end
      end
    end
    n_edge++;
  endtask

  // One clock: drive, let the edge happen, update the model, compare on the falling edge.
  task automatic step_edge(input bit r, input bit pb, input bit w);
    rst    = r;
    pb_raw = pb;
    w_raw  = w;
    @(posedge clk);
    model_edge(r, pb, w);
    @(negedge clk);
    check("model_step",      32'(step),      32'(m_step));
    check("model_pb_level",  32'(pb_level),  32'(m_lvl[0]));
    check("model_w_level",   32'(w_level),   32'(m_lvl[1]));
    check("model_press_cnt", 32'(press_cnt), 32'(m_cnt));
    if (step === 1'b1) steps_seen++;
  endtask

  typedef struct {
    bit   rst;
    bit   pb;
    bit   w;
    int   cycles;
    int   exp_steps;
    bit   exp_pbl;
    bit   exp_wl;
    int   exp_cnt;
  } seg_t;

  seg_t segs[$];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int s0;
    bit pb_v, w_v, r_v;
    int pb_run, w_run;

    rst = 1'b1; pb_raw = 1'b1; w_raw = 1'b0;
    for (int ch = 0; ch < 2; ch++) begin
      m_lvl[ch]    = 1'b0;
      last_evt[ch] = 7;
    end
    m_cnt = 8'd0;

    // rst pb w cycles steps pb_level w_level press_cnt
    segs.push_back('{1'b1, 1'b1, 1'b0,  2, 0, 1'b0, 1'b0, 0}); // reset
    segs.push_back('{1'b0, 1'b1, 1'b0, 20, 0, 1'b0, 1'b0, 0}); // idle after reset
    segs.push_back('{1'b0, 1'b0, 1'b0, 20, 1, 1'b1, 1'b0, 1}); // clean press
    segs.push_back('{1'b0, 1'b1, 1'b0, 10, 0, 1'b0, 1'b0, 1}); // release, no step
    segs.push_back('{1'b0, 1'b0, 1'b0,  1, 0, 1'b0, 1'b0, 1}); // bounce
    segs.push_back('{1'b0, 1'b1, 1'b0,  1, 0, 1'b0, 1'b0, 1});
    segs.push_back('{1'b0, 1'b0, 1'b0,  1, 0, 1'b0, 1'b0, 1});
    segs.push_back('{1'b0, 1'b1, 1'b0,  1, 0, 1'b0, 1'b0, 1});
    segs.push_back('{1'b0, 1'b0, 1'b0, 20, 1, 1'b1, 1'b0, 2}); // steady after bounce
    segs.push_back('{1'b0, 1'b1, 1'b0, 10, 0, 1'b0, 1'b0, 2});
    segs.push_back('{1'b0, 1'b0, 1'b0,  3, 0, 1'b0, 1'b0, 2}); // 3-cycle glitch
    segs.push_back('{1'b0, 1'b1, 1'b0, 10, 0, 1'b0, 1'b0, 2});
    segs.push_back('{1'b0, 1'b1, 1'b1, 10, 0, 1'b0, 1'b1, 2}); // w to 1
    segs.push_back('{1'b0, 1'b0, 1'b1, 20, 1, 1'b1, 1'b1, 3}); // press with w=1
    segs.push_back('{1'b0, 1'b1, 1'b1, 10, 0, 1'b0, 1'b1, 3});
    segs.push_back('{1'b0, 1'b1, 1'b0,  1, 0, 1'b0, 1'b1, 3}); // 1-cycle w pulse
    segs.push_back('{1'b0, 1'b1, 1'b1, 10, 0, 1'b0, 1'b1, 3});
    segs.push_back('{1'b0, 1'b0, 1'b0, 20, 1, 1'b1, 1'b0, 4}); // simultaneous pb/w commit
    segs.push_back('{1'b0, 1'b1, 1'b0, 10, 0, 1'b0, 1'b0, 4});

    foreach (segs[i]) begin
      s0 = steps_seen;
      for (int c = 0; c < segs[i].cycles; c++) begin
        step_edge(segs[i].rst, segs[i].pb, segs[i].w);
        if (step === 1'b1)
          check($sformatf("seg%0d_w_at_step", i), 32'(w_level), 32'(segs[i].exp_wl));
      end
      check($sformatf("seg%0d_steps", i),     steps_seen - s0,   segs[i].exp_steps);
      check($sformatf("seg%0d_pb_level", i),  32'(pb_level),     32'(segs[i].exp_pbl));
      check($sformatf("seg%0d_w_level", i),   32'(w_level),      32'(segs[i].exp_wl));
      check($sformatf("seg%0d_press_cnt", i), 32'(press_cnt),    segs[i].exp_cnt);
    end

    // Exact latency: step only in the cycle after edge 5.
    for (int k = 0; k < 20; k++) begin
      step_edge(1'b0, 1'b0, 1'b0);
      check($sformatf("lat_step_e%0d", k),  32'(step),      32'(k == 5));
      check($sformatf("lat_level_e%0d", k), 32'(pb_level),  32'(k >= 5));
      check($sformatf("lat_cnt_e%0d", k),   32'(press_cnt), (k >= 5) ? 5 : 4);
    end
    for (int k = 0; k < 10; k++) step_edge(1'b0, 1'b1, 1'b0);

    // Reset mid PRESS_WAIT: the pending commit is discarded.
    s0 = steps_seen;
    for (int k = 0; k < 4; k++) step_edge(1'b0, 1'b0, 1'b0);
    step_edge(1'b1, 1'b1, 1'b0);
    for (int k = 0; k < 12; k++) step_edge(1'b0, 1'b1, 1'b0);
    check("midwait_steps",     steps_seen - s0, 0);
    check("midwait_press_cnt", 32'(press_cnt),  0);
    check("midwait_pb_level",  32'(pb_level),   0);

    // Reset while held: one step, edge 5 after the first non-reset edge, no repeats.
    for (int k = 0; k < 10; k++) step_edge(1'b0, 1'b0, 1'b0);
    step_edge(1'b1, 1'b0, 1'b0);
    check("held_rst_cnt", 32'(press_cnt), 0);
    s0 = steps_seen;
    for (int k = 0; k < 30; k++) begin
      step_edge(1'b0, 1'b0, 1'b0);
      check($sformatf("held_step_e%0d", k), 32'(step), 32'(k == 5));
    end
    check("held_steps",     steps_seen - s0, 1);
    check("held_press_cnt", 32'(press_cnt),  1);
    for (int k = 0; k < 10; k++) step_edge(1'b0, 1'b1, 1'b0);

    // 256 clean presses from reset: counter wraps back to 0.
    step_edge(1'b1, 1'b1, 1'b0);
    s0 = steps_seen;
    for (int p = 0; p < 256; p++) begin
      for (int k = 0; k < 6; k++) step_edge(1'b0, 1'b0, 1'b0);
      for (int k = 0; k < 6; k++) step_edge(1'b0, 1'b1, 1'b0);
      if (p == 254) check("wrap_cnt_255", 32'(press_cnt), 255);
    end
    check("wrap_steps",     steps_seen - s0, 256);
    check("wrap_press_cnt", 32'(press_cnt),  0);

    // Randomized bouncing pins with occasional reset.
    pb_v = 1'b1; w_v = 1'b0; pb_run = 0; w_run = 0;
    for (int i = 0; i < 3000; i++) begin
      if (pb_run == 0) begin
        pb_v   = ~pb_v;
        pb_run = $urandom_range(1, 9);
      end
      if (w_run == 0) begin
        w_v   = ~w_v;
        w_run = $urandom_range(1, 9);
      end
      r_v = ($urandom_range(0, 149) == 0);
      step_edge(r_v, pb_v, w_v);
      pb_run--;
      w_run--;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
